// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - single-port RAM access controller with request/response handshakes
//
// Purpose:
//   Accepts one client request at a time and turns it into RAM port activity.
//   A write request becomes a single-cycle RAM write. A read request presents
//   the address, waits out the RAM read latency, captures the data, and holds
//   the response until the client takes it.
//
// Ports:
//   clka       in   clock, all state on the rising edge
//   rsta       in   asynchronous active-high reset
//   req_valid  in   client request present
//   req_ready  out  request accepted this cycle (IDLE only, low during reset)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   request word address
//   req_wdata  in   write data
//   rsp_valid  out  read data available, held until taken
//   rsp_ready  in   client takes read data
//   rsp_rdata  out  read data
//   wr_done    out  one-cycle pulse when a write is issued to the RAM
//   wea        out  RAM write enable (registered)
//   addra      out  RAM address (registered)
//   dina       out  RAM write data (registered)
//   douta      in   RAM read data, valid RD_LAT cycles after the address is sampled

module mem_port_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Three bits covers the full 1..4 latency range.
  localparam int CNT_W = 3;

  state_t              state_q,     state_d;
  logic                wea_q,       wea_d;
  logic                wr_done_q,   wr_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   addra_q,     addra_d;
  logic [DATA_W-1:0]   dina_q,      dina_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  // Gated by reset so the client never sees ready while the block is held.
  assign req_ready = (state_q == IDLE) && !rsta;

  always_comb begin
    state_d     = state_q;
    wea_d       = 1'b0;
    wr_done_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    addra_d     = addra_q;
    dina_d      = dina_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addra_d = req_addr;
          if (req_we) begin
            dina_d    = req_wdata;
            wea_d     = 1'b1;
            wr_done_d = 1'b1;
            state_d   = WRITE;
          end else begin
            cnt_d   = CNT_W'(RD_LAT);
            state_d = RD_WAIT;
          end
        end
      end

      // The write happens at the end of this cycle; nothing to wait for.
      WRITE: begin
        state_d = IDLE;
      end

      // Counter starts at RD_LAT in the cycle the address is presented, so
      // reaching zero lines up with douta carrying the addressed word.
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = douta;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q     <= IDLE;
      wea_q       <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wea_q       <= wea_d;
      wr_done_q   <= wr_done_d;
      rsp_valid_q <= rsp_valid_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wea       = wea_q;
  assign wr_done   = wr_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addra     = addra_q;
  assign dina      = dina_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - scoreboard bench for mem_port_ctrl (RD_LAT=1 and RD_LAT=3 instances)

module tb_mem_port_ctrl;

  logic        clk;
  logic        rsta;

  // RD_LAT=1 instance
  logic        req_valid, req_ready, req_we;
  logic [10:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        wr_done, wea;
  logic [10:0] addra;
  logic [15:0] dina, douta;

  // RD_LAT=3 instance
  logic        req3_valid, req3_ready, req3_we;
  logic [10:0] req3_addr;
  logic [15:0] req3_wdata;
  logic        rsp3_valid, rsp3_ready;
  logic [15:0] rsp3_rdata;
  logic        wr_done3, wea3;
  logic [10:0] addra3;
  logic [15:0] dina3, douta3;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] exp_rd [$];
  logic [26:0] exp_wr [$];
  logic [15:0] exp_rd3 [$];

  mem_port_ctrl #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1)) u_dut (
    .clka(clk), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
  );

  mem_port_ctrl #(.ADDR_W(11), .DATA_W(16), .RD_LAT(3)) u_dut3 (
    .clka(clk), .rsta(rsta),
    .req_valid(req3_valid), .req_ready(req3_ready), .req_we(req3_we),
    .req_addr(req3_addr), .req_wdata(req3_wdata),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_rdata(rsp3_rdata),
    .wr_done(wr_done3), .wea(wea3), .addra(addra3), .dina(dina3), .douta(douta3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, one-cycle read latency.
  logic [15:0] mem1 [0:2047];
  logic [15:0] pipe1;
  always @(posedge clk) begin
    if (wea) mem1[addra] <= dina;
    pipe1 <= mem1[addra];
  end
  assign douta = pipe1;

  // ROM model, three-cycle read latency; word = 0xA000 | address.
  logic [15:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    p3a <= 16'hA000 | {5'd0, addra3};
    p3b <= p3a;
    p3c <= p3b;
  end
  assign douta3 = p3c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expectations on each observed response/write.
  always @(negedge clk) begin
    logic [26:0] e;
    if (rsp_valid && rsp_ready) begin
      if (exp_rd.size() == 0) fail_now("unexpected_rsp");
      else chk("rsp_rdata", rsp_rdata, exp_rd.pop_front());
    end
    if (wr_done) begin
      if (exp_wr.size() == 0) fail_now("unexpected_wr_done");
      else begin
        e = exp_wr.pop_front();
        chk("wr_addra", addra, e[26:16]);
        chk("wr_dina", dina, e[15:0]);
        chk("wr_wea", wea, 1);
      end
    end
    if (rsp3_valid && rsp3_ready) begin
      if (exp_rd3.size() == 0) fail_now("unexpected_rsp3");
      else chk("rsp3_rdata", rsp3_rdata, exp_rd3.pop_front());
    end
    if (wea3 || wr_done3) begin
      n_checks++;
      n_err++;
      $display("FAIL lat3_unexpected_write: wea=%0d dina=0x%0h expected no write", wea3, dina3);
    end
  end

  // Presents a request and returns in the cycle after acceptance (+1).
  task automatic issue(input logic we, input logic [10:0] addr, input logic [15:0] data,
                       input bit push, output int waits);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    waits     = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      if (we) exp_wr.push_back({addr, data});
      else    exp_rd.push_back(data);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 30) begin
      step();
      n++;
    end
    if (!req_ready) fail_now("idle_timeout");
  endtask

  initial begin
    int w;
    int n;
    rsta = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req3_valid = 0; req3_we = 0; req3_addr = '0; req3_wdata = '0; rsp3_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wea", wea, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rsta = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // Single write
    issue(1'b1, 11'd1, 16'h0001, 1, w);
    chk("wr_wea_n1", wea, 1);
    chk("wr_addra_n1", addra, 11'd1);
    chk("wr_dina_n1", dina, 16'h0001);
    chk("wr_done_n1", wr_done, 1);
    chk("wr_req_ready_n1", req_ready, 0);
    step();
    chk("wr_wea_n2", wea, 0);
    chk("wr_done_n2", wr_done, 0);
    chk("wr_req_ready_n2", req_ready, 1);

    // Read-back of 0xBEEF at the top address, RD_LAT=1
    issue(1'b1, 11'h7FF, 16'hBEEF, 1, w);
    step();
    issue(1'b0, 11'h7FF, 16'hBEEF, 1, w);
    chk("rd_valid_n1", rsp_valid, 0);
    chk("rd_wea_n1", wea, 0);
    chk("rd_addra_n1", addra, 11'h7FF);
    step();
    chk("rd_valid_n2", rsp_valid, 0);
    step();
    chk("rd_valid_n3", rsp_valid, 1);
    chk("rd_rdata_n3", rsp_rdata, 16'hBEEF);
    step();
    chk("rd_valid_n4", rsp_valid, 0);
    chk("rd_ready_n4", req_ready, 1);

    // Backpressure on the response while new requests are offered
    rsp_ready = 1'b0;
    issue(1'b0, 11'd1, 16'h0001, 1, w);
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    if (!rsp_valid) fail_now("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_we    = k[0];
      req_addr  = 11'(k + 5);
      req_wdata = 16'(k + 16'h0100);
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 16'h0001);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_wea", wea, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_released_valid", rsp_valid, 0);
    chk("bp_released_ready", req_ready, 1);

    // Back-to-back writes: one accept every second cycle
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 11'(k), 16'(16'h0010 + k), 1, w);
      chk("b2b_wea", wea, 1);
      if (k > 0) chk("b2b_wait_cycles", w, 1);
    end
    step();
    chk("b2b_wea_after", wea, 0);
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 11'(k), 16'(16'h0010 + k), 1, w);
    end
    wait_idle();

    // Reset during RD_WAIT: response discarded, outputs cleared at once
    issue(1'b1, 11'd9, 16'h0909, 1, w);
    issue(1'b0, 11'h7FF, 16'h0000, 0, w);
    rsta = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_addra", addra, 0);
    chk("mid_rst_dina", dina, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    step();
    step();
    chk("mid_rst_valid_held", rsp_valid, 0);
    rsta = 1'b0;
    #1;
    chk("mid_rst_ready_after", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    issue(1'b0, 11'h7FF, 16'hBEEF, 1, w);
    wait_idle();

    // Reset while WRITE is on the RAM port: wea drops immediately
    issue(1'b1, 11'd5, 16'h5555, 0, w);
    chk("wrst_wea_before", wea, 1);
    rsta = 1'b1;
    #1;
    chk("wrst_wea_after", wea, 0);
    chk("wrst_wr_done_after", wr_done, 0);
    step();
    rsta = 1'b0;
    step();

    // RD_LAT=3 instance: response first at accept+5
    req3_valid = 1'b1;
    req3_addr  = 11'd2;
    @(negedge clk);
    chk("lat3_req_ready", req3_ready, 1);
    @(posedge clk);
    #1;
    req3_valid = 1'b0;
    exp_rd3.push_back(16'hA002);
    for (int i = 0; i < 4; i++) begin
      chk("lat3_valid_early", rsp3_valid, 0);
      step();
    end
    chk("lat3_valid_n5", rsp3_valid, 1);
    chk("lat3_rdata_n5", rsp3_rdata, 16'hA002);
    step();
    chk("lat3_valid_n6", rsp3_valid, 0);

    step(); step(); step();
    chk("sb_rd_drained", exp_rd.size(), 0);
    chk("sb_wr_drained", exp_wr.size(), 0);
    chk("sb_rd3_drained", exp_rd3.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles, legal range 1-4.
REQ-004 SHALL have port clka  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rsta  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  client request present.
REQ-007 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  request word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data available.
REQ-012 SHALL have port rsp_ready  input  1  client takes read data.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-014 SHALL have port wr_done  output  1  one-cycle pulse, write issued to RAM.
REQ-015 SHALL have port wea  output  1  RAM write enable.
REQ-016 SHALL have port addra  output  ADDR_W  RAM address.
REQ-017 SHALL have port dina  output  DATA_W  RAM write data.
REQ-018 SHALL have port douta  input  DATA_W  RAM read data, valid RD_LAT cycles after address sampled.

Function
REQ-019 SHALL implement states IDLE, WRITE, RD_WAIT, RESP; every RAM-side output is a register.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-021 On write accepted at edge of cycle N: SHALL, in cycle N+1, present wea=1, addra=req_addr, dina=req_wdata, wr_done=1, state WRITE.
REQ-022 SHALL, from WRITE, return to IDLE unconditionally after one cycle; wea and wr_done are high for exactly one cycle per write.
REQ-023 On read accepted at edge of cycle N: SHALL present addra=req_addr, wea=0 from cycle N+1 and enter RD_WAIT with latency counter loaded to RD_LAT.
REQ-024 SHALL, in RD_WAIT, decrement the counter each cycle; when the counter reaches 0, capture douta into rsp_rdata and enter RESP (rsp_valid=1 first in cycle N+2+RD_LAT).
REQ-025 SHALL, in RESP, hold rsp_valid=1 and rsp_rdata stable until rsp_valid & rsp_ready at a rising edge, then return to IDLE.
REQ-026 SHALL keep addra and dina unchanged outside accepted requests; wea=0 in every state except WRITE.
REQ-027 SHALL ignore req_valid and all req_* inputs while req_ready=0 (no queuing, no loss of held response).
REQ-028 SHALL ignore rsp_ready outside RESP.
REQ-029 SHALL support back-to-back writes: throughput one write per 2 cycles (accept, WRITE, accept...).
REQ-030 SHALL return rsp_rdata equal to data of a write to the same address completed before the read was accepted.

Reset
REQ-031 SHALL, on rsta=1 asynchronously: state=IDLE, wea=0, wr_done=0, rsp_valid=0, addra=0, dina=0, rsp_rdata=0, latency counter=0.
REQ-032 SHALL abort any operation in progress on reset mid-operation; a write in WRITE has wea forced to 0 immediately; a pending read response is discarded.
REQ-033 SHALL drive req_ready=0 while rsta=1 and req_ready=1 in the first cycle after rsta deasserts.

Verification
REQ-034 Write: after reset, req_we=1, addr=1, wdata=0x0001 accepted -> next cycle wea=1, addra=1, dina=0x0001, wr_done=1; following cycle wea=0, req_ready=1.
REQ-035 Read-back: write 0xBEEF to addr 0x7FF, then read addr 0x7FF with rsp_ready=1 -> rsp_valid at accept+3 cycles (RD_LAT=1), rsp_rdata=0xBEEF, one-cycle rsp_valid.
REQ-036 Backpressure: read addr 1 with rsp_ready=0 for 5 cycles while req_valid=1 toggles req_addr -> rsp_valid and rsp_rdata=0x0001 stable, req_ready=0, wea=0 throughout; released on rsp_ready=1.
REQ-037 Back-to-back writes: 4 writes addr 0..3 data 0x10..0x13 with req_valid held -> wea pulses in alternate cycles, 4 wr_done pulses, read-back returns 0x10..0x13.
REQ-038 Reset mid-read: assert rsta during RD_WAIT -> rsp_valid never asserts, outputs at reset values, next read completes normally.
REQ-039 Latency: RD_LAT=3 build, read addr 2 -> rsp_valid first at accept+5 cycles with correct data.
